// File: rtl/game_event_sched.sv
// Maze game event scheduler: arbitrates coin/level/hit events onto a BCD
// score adder, level and lives registers. SCORE_BONUS_EN scales level points.
module game_event_sched #(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned MAX_LEVEL   = 9,
  parameter logic [7:0]  COIN_PTS    = 8'h10,
  parameter logic [7:0]  LEVEL_PTS   = 8'h50
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clr,
  input  logic        coin_req,
  input  logic        level_req,
  input  logic        hit_req,
  output logic [15:0] score_bcd,
  output logic [3:0]  level,
  output logic [1:0]  lives,
  output logic [2:0]  ack,
  output logic        busy,
  output logic        game_over
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADD0 = 3'd1;
  localparam logic [2:0] ADD1 = 3'd2;
  localparam logic [2:0] ADD2 = 3'd3;
  localparam logic [2:0] ADD3 = 3'd4;
  localparam logic [2:0] LIFE = 3'd5;
  localparam logic [2:0] OVER = 3'd6;

  localparam logic [3:0] MAX_LV  = 4'(MAX_LEVEL);
  localparam logic [1:0] LIVES0  = 2'(START_LIVES);

  logic [2:0] state;
  logic [1:0] coin_pend;
  logic       lvl_pend;
  logic       hit_pend;
  logic [7:0] addend;
  logic [3:0] passes;
  logic       carry;

  logic       idle;
  logic       g_hit;
  logic       g_lvl;
  logic       g_coin;
  logic [1:0] coin_nx;
  logic       lvl_nx;
  logic       hit_nx;
  logic [3:0] lvl_inc;
  logic [3:0] pass_load;

  logic [1:0] dsel;
  logic [3:0] cur;
  logic [3:0] ad;
  logic [4:0] sum;
  logic [3:0] dig;
  logic       cout;

  // clr wins over any grant in the same cycle
  assign idle   = (state == IDLE) && !clr;
  assign g_hit  = idle && hit_pend;
  assign g_lvl  = idle && !hit_pend && lvl_pend;
  assign g_coin = idle && !hit_pend && !lvl_pend && (coin_pend != 2'd0);

  assign ack       = {g_hit, g_lvl, g_coin};
  assign busy      = (state >= ADD0) && (state <= LIFE);
  assign game_over = (state == OVER);

  assign lvl_inc = (level >= MAX_LV) ? MAX_LV : level + 4'd1;

`ifdef SCORE_BONUS_EN
  assign pass_load = lvl_inc;
`else
  assign pass_load = 4'd1;
`endif

  always_comb begin
    coin_nx = coin_pend;
    unique case ({coin_req, g_coin})
      2'b10:   coin_nx = (coin_pend == 2'd3) ? 2'd3 : coin_pend + 2'd1;
      2'b01:   coin_nx = coin_pend - 2'd1;
      default: coin_nx = coin_pend;
    endcase
  end

  assign lvl_nx = (lvl_pend && !g_lvl) || level_req;
  assign hit_nx = (hit_pend && !g_hit) || hit_req;

  // one BCD digit per ADD state, digit index follows the state
  always_comb begin
    dsel = 2'(state - ADD0);
    cur  = score_bcd[{dsel, 2'b00} +: 4];
    unique case (dsel)
      2'd0:    ad = addend[3:0];
      2'd1:    ad = addend[7:4];
      default: ad = 4'd0;
    endcase
    sum  = {1'b0, cur} + {1'b0, ad}
         + {4'd0, carry && (state != ADD0)};
    cout = (sum > 5'd9);
    dig  = cout ? 4'(sum - 5'd10) : sum[3:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      coin_pend <= 2'd0;
      lvl_pend  <= 1'b0;
      hit_pend  <= 1'b0;
      addend    <= 8'h00;
      passes    <= 4'd0;
      carry     <= 1'b0;
      score_bcd <= 16'h0000;
      level     <= 4'd1;
      lives     <= LIVES0;
    end else if (clr) begin
      state     <= IDLE;
      coin_pend <= 2'd0;
      lvl_pend  <= 1'b0;
      hit_pend  <= 1'b0;
      addend    <= 8'h00;
      passes    <= 4'd0;
      carry     <= 1'b0;
      score_bcd <= 16'h0000;
      level     <= 4'd1;
      lives     <= LIVES0;
    end else begin
      if (state == OVER) begin
        coin_pend <= 2'd0;
        lvl_pend  <= 1'b0;
        hit_pend  <= 1'b0;
      end else begin
        coin_pend <= coin_nx;
        lvl_pend  <= lvl_nx;
        hit_pend  <= hit_nx;
      end
      unique case (state)
        IDLE: begin
          if (g_hit) begin
            state <= LIFE;
          end else if (g_lvl) begin
            level  <= lvl_inc;
            passes <= pass_load;
            addend <= LEVEL_PTS;
            state  <= ADD0;
          end else if (g_coin) begin
            passes <= 4'd1;
            addend <= COIN_PTS;
            state  <= ADD0;
          end
        end
        ADD0, ADD1, ADD2: begin
          score_bcd[{dsel, 2'b00} +: 4] <= dig;
          carry <= cout;
          state <= state + 3'd1;
        end
        ADD3: begin
          if (cout) score_bcd <= 16'h9999;
          else      score_bcd[15:12] <= dig;
          carry  <= 1'b0;
          passes <= passes - 4'd1;
          state  <= (passes == 4'd1) ? IDLE : ADD0;
        end
        LIFE: begin
          lives <= lives - 2'd1;
          state <= (lives == 2'd1) ? OVER : IDLE;
        end
        OVER:    state <= OVER;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_event_sched.sv
// Directed self-checking bench for game_event_sched.
// Expected values are hand-computed; SCORE_BONUS_EN selects the bonus set.
module tb_game_event_sched;

  logic        Clk;
  logic        Reset;
  logic        clr;
  logic        coin_req;
  logic        level_req;
  logic        hit_req;
  logic [15:0] score_bcd;
  logic [3:0]  level;
  logic [1:0]  lives;
  logic [2:0]  ack;
  logic        busy;
  logic        game_over;

  int total = 0;
  int bad   = 0;

`ifdef SCORE_BONUS_EN
  localparam logic [15:0] SIM_SCORE = 16'h0110;
  localparam logic [15:0] SAT_SCORE = 16'h0130;
  localparam logic [15:0] LVL_SCORE = 16'h3100;
`else
  localparam logic [15:0] SIM_SCORE = 16'h0060;
  localparam logic [15:0] SAT_SCORE = 16'h0080;
  localparam logic [15:0] LVL_SCORE = 16'h0500;
`endif

  game_event_sched dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr       (clr),
    .coin_req  (coin_req),
    .level_req (level_req),
    .hit_req   (hit_req),
    .score_bcd (score_bcd),
    .level     (level),
    .lives     (lives),
    .ack       (ack),
    .busy      (busy),
    .game_over (game_over)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_quiet(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (!busy && ack == 3'b000) done = 1'b1;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_ack(input string tag, input logic [2:0] exp);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (ack != 3'b000) done = 1'b1;
    end
    chk(tag, {29'd0, ack}, {29'd0, exp});
  endtask

  task automatic do_coin(input string tag);
    coin_req = 1'b1;
    tick();
    coin_req = 1'b0;
    wait_quiet(tag);
  endtask

  task automatic do_level(input string tag);
    level_req = 1'b1;
    tick();
    level_req = 1'b0;
    wait_quiet(tag);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score"}, {16'd0, score_bcd}, 32'h0000);
    chk({tag, "_level"}, {28'd0, level}, 32'd1);
    chk({tag, "_lives"}, {30'd0, lives}, 32'd3);
    chk({tag, "_ack"},   {29'd0, ack}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_over"},  {31'd0, game_over}, 32'd0);
  endtask

  initial begin
    int n;
    Reset     = 1'b0;
    clr       = 1'b0;
    coin_req  = 1'b0;
    level_req = 1'b0;
    hit_req   = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");
    Reset = 1'b1;
    tick();

    // single coin: ack next cycle, busy 4 cycles, score final after
    coin_req = 1'b1;
    tick();
    coin_req = 1'b0;
    chk("coin_ack", {29'd0, ack}, 32'b001);
    chk("coin_grant_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("coin_busy", {31'd0, busy}, 32'd1);
      chk("coin_ack_off", {29'd0, ack}, 32'd0);
    end
    tick();
    chk("coin_done_busy", {31'd0, busy}, 32'd0);
    chk("coin_score", {16'd0, score_bcd}, 32'h0010);

    // decimal carry from digit 1 into digit 2
    for (int i = 0; i < 8; i++) do_coin("coin_q");
    chk("pre_carry", {16'd0, score_bcd}, 32'h0090);
    do_coin("carry_q");
    chk("carry_score", {16'd0, score_bcd}, 32'h0100);

    // clear in ADD2 of a coin add
    do_clr();
    coin_req = 1'b1;
    tick();
    coin_req = 1'b0;
    tick();
    tick();
    tick();
    clr = 1'b1;
    tick();
    chk_reset_vals("midclr");
    clr = 1'b0;
    repeat (6) tick();
    chk("midclr_noreadd", {16'd0, score_bcd}, 32'h0000);
    chk("midclr_idle", {31'd0, busy}, 32'd0);

    // simultaneous events: hit, then level, then coin
    coin_req  = 1'b1;
    level_req = 1'b1;
    hit_req   = 1'b1;
    tick();
    coin_req  = 1'b0;
    level_req = 1'b0;
    hit_req   = 1'b0;
    chk("sim_ack_hit", {29'd0, ack}, 32'b100);
    wait_ack("sim_ack_lvl", 3'b010);
    chk("sim_lives", {30'd0, lives}, 32'd2);
    wait_ack("sim_ack_coin", 3'b001);
    chk("sim_level", {28'd0, level}, 32'd2);
    wait_quiet("sim_q");
    chk("sim_score", {16'd0, score_bcd}, {16'd0, SIM_SCORE});

    // coin pending saturates at 3 during a level add
    do_clr();
    level_req = 1'b1;
    tick();
    level_req = 1'b0;
    chk("sat_lvl_ack", {29'd0, ack}, 32'b010);
    coin_req = 1'b1;
    repeat (5) tick();
    coin_req = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (ack == 3'b001) n++;
      tick();
    end
    chk("sat_coin_acks", n, 32'd3);
    chk("sat_score", {16'd0, score_bcd}, {16'd0, SAT_SCORE});
    chk("sat_level", {28'd0, level}, 32'd2);

    // score saturation at 9999
    do_clr();
    for (int i = 0; i < 999; i++) do_coin("fill_q");
    chk("fill_score", {16'd0, score_bcd}, 32'h9990);
    do_coin("top_q");
    chk("top_score", {16'd0, score_bcd}, 32'h9999);
    do_coin("top2_q");
    chk("top2_score", {16'd0, score_bcd}, 32'h9999);

    // lives exhaustion with hits 5 cycles apart
    for (int h = 0; h < 3; h++) begin
      hit_req = 1'b1;
      tick();
      hit_req = 1'b0;
      repeat (4) tick();
      chk("hit_lives", {30'd0, lives}, 32'(2 - h));
      chk("hit_over", {31'd0, game_over}, (h == 2) ? 32'd1 : 32'd0);
    end
    coin_req  = 1'b1;
    level_req = 1'b1;
    tick();
    coin_req  = 1'b0;
    level_req = 1'b0;
    chk("over_ack", {29'd0, ack}, 32'd0);
    repeat (6) begin
      tick();
      chk("over_ack_hold", {29'd0, ack}, 32'd0);
    end
    chk("over_score", {16'd0, score_bcd}, 32'h9999);
    chk("over_level", {28'd0, level}, 32'd1);
    chk("over_busy", {31'd0, busy}, 32'd0);
    chk("over_hold", {31'd0, game_over}, 32'd1);
    do_clr();
    chk_reset_vals("over_clr");

    // level saturates at MAX_LEVEL
    for (int i = 0; i < 8; i++) do_level("lvl_q");
    chk("lvl_at_max", {28'd0, level}, 32'd9);
    do_level("lvl_q");
    do_level("lvl_q");
    chk("lvl_sat", {28'd0, level}, 32'd9);
    chk("lvl_score", {16'd0, score_bcd}, {16'd0, LVL_SCORE});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
